// File: rtl/life_scan_pkg.sv
// life_scan_pkg: shared defaults and row/popcount helpers for the life scan receiver.
package life_scan_pkg;
  localparam int DEF_MIN_DWELL = 4;
  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_ROWS = 64;
  localparam int MAX_CELLS = 1024;
  typedef logic [MAX_ROWS-1:0] row_vec_t;
  typedef logic [MAX_CELLS-1:0] cell_vec_t;
  typedef logic [7:0] row_idx_t;
  typedef logic [10:0] pop_t;
  function automatic row_idx_t onehot_idx(row_vec_t v);
    row_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_ROWS; i++) if (v[i]) idx = idx | row_idx_t'(i);
    return idx;
  endfunction
  function automatic logic is_onehot(row_vec_t v);
    return (v != '0) && ((v & (v - row_vec_t'(1))) == '0);
  endfunction
  function automatic pop_t popcount(cell_vec_t v);
    pop_t n;
    n = '0;
    for (int i = 0; i < MAX_CELLS; i++) n = n + pop_t'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/life_scan_dwell.sv
// life_scan_dwell: input sampling, per-row dwell filter, capture strobe and multi-hot/tear detection.
module life_scan_dwell
  import life_scan_pkg::*;
#(
  parameter int X = 8,
  parameter int Y = 8,
  parameter int LOG2X = 3,
  parameter int MIN_DWELL = DEF_MIN_DWELL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [X-1:0]     row,
  input  logic [Y-1:0]     col,
  output logic             cap,
  output logic [LOG2X-1:0] idx,
  output logic [Y-1:0]     data,
  output logic             err_multi,
  output logic             err_tear
);
  localparam int DW = $clog2(MIN_DWELL) + 1;
  logic [X-1:0] s1_row, s2_row;
  logic [Y-1:0] s1_col, cap_col;
  logic [DW-1:0] dwell;
  logic hot, same, held;
  assign hot = is_onehot(row_vec_t'(s1_row));
  assign same = hot && (s1_row == s2_row);
  assign held = dwell == DW'(MIN_DWELL - 1);
  // dwell counts repeats, so the MIN_DWELL-th sample is present when dwell reads MIN_DWELL-2
  assign cap = same && (dwell == DW'(MIN_DWELL - 2));
  assign idx = LOG2X'(onehot_idx(row_vec_t'(s1_row)));
  assign data = s1_col;
  assign err_multi = (s1_row != '0) && !hot;
  assign err_tear = same && held && (s1_col != cap_col);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1_row <= '0;
      s2_row <= '0;
      s1_col <= '0;
      cap_col <= '0;
      dwell <= '0;
    end else begin
      s1_row <= row;
      s2_row <= s1_row;
      s1_col <= col;
      dwell <= !same ? '0 : (cap || held) ? DW'(MIN_DWELL - 1) : dwell + DW'(1);
      if (cap) cap_col <= s1_col;
    end
endmodule

// File: rtl/life_scan_rx.sv
// life_scan_rx: reassembles LED-matrix scan frames from row/col lines with dwell filtering.
// Define LIFE_SCAN_RX_POP_EN to register a live-cell count alongside each published frame.
module life_scan_rx
  import life_scan_pkg::*;
#(
  parameter int X = 8,
  parameter int Y = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int MIN_DWELL = DEF_MIN_DWELL,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [X-1:0]           row,
  input  logic [Y-1:0]           col,
  output logic [X*Y-1:0]         frame,
  output logic                   frame_valid,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic                   err_multi,
  output logic                   err_tear,
  output logic                   stall,
  output logic [LOG2X+LOG2Y:0]   pop
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = LOG2X + LOG2Y + 1;
  logic cap, done, tmo;
  logic [LOG2X-1:0] idx;
  logic [Y-1:0] data;
  logic [X*Y-1:0] buffer;
  logic [X-1:0] seen;
  logic [TW-1:0] tcnt, tcnt_nxt;
  life_scan_dwell #(.X(X), .Y(Y), .LOG2X(LOG2X), .MIN_DWELL(MIN_DWELL)) u_dwell (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .cap(cap),
    .idx(idx),
    .data(data),
    .err_multi(err_multi),
    .err_tear(err_tear)
  );
  assign done = &seen;
  assign tcnt_nxt = cap ? '0 : (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + TW'(1);
  // a saturated timeout keeps discarding any partial frame until the next capture
  assign tmo = tcnt_nxt == TW'(TIMEOUT);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      buffer <= '0;
      seen <= '0;
      tcnt <= '0;
      stall <= 1'b0;
      frame <= '0;
      frame_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      tcnt <= tcnt_nxt;
      stall <= tmo || (stall && !cap);
      frame_valid <= done;
      seen <= (done || tmo) ? '0 : cap ? (seen | (X'(1) << idx)) : seen;
      if (cap) buffer[int'(idx)*Y +: Y] <= data;
      if (done) begin
        frame <= buffer;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
`ifdef LIFE_SCAN_RX_POP_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) pop <= '0;
    else if (done) pop <= PW'(popcount(cell_vec_t'(buffer)));
`else
  assign pop = '0;
`endif
endmodule

// File: tb/tb_life_scan_rx.sv
// tb_life_scan_rx: scoreboard bench for life_scan_rx; a dwell-level model predicts frames and error pulses.
module tb_life_scan_rx;
  localparam int M = 4;
  localparam int TMO = 1024;
  logic clk = 0;
  logic rst_n = 1;
  logic [7:0] row = 0;
  logic [7:0] col = 0;
  logic [63:0] frame;
  logic frame_valid, err_multi, err_tear, stall;
  logic [15:0] frame_cnt;
  logic [6:0] pop;

  life_scan_rx dut (
    .clk(clk), .reset(rst_n), .row(row), .col(col), .frame(frame), .frame_valid(frame_valid),
    .frame_cnt(frame_cnt), .err_multi(err_multi), .err_tear(err_tear), .stall(stall), .pop(pop)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] f; int e; int cnt; int pop; } exp_t;
  exp_t q[$];
  int edge_n = 0, checks = 0, passed = 0;
  int exp_multi = 0, exp_tear = 0, dut_multi = 0, dut_tear = 0;
  logic [63:0] mbuf = 0;
  logic [7:0] mseen = 0;
  logic [7:0] prev_row = 0;
  int mcnt = 0, last_cap = 0;

  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
  endtask

  function automatic int idx_of(input logic [7:0] r);
    for (int i = 0; i < 8; i++) if (r[i]) return i;
    return 0;
  endfunction

  function automatic int pop_of(input logic [63:0] f);
`ifdef LIFE_SCAN_RX_POP_EN
    return $countones(f);
`else
    return 0;
`endif
  endfunction

  // One dwell of a row: captured once if one-hot and long enough, value is the MIN_DWELL-th sample.
  task automatic model(input logic [7:0] r, input int n, input logic [7:0] c0, input int chg,
                       input logic [7:0] c1, input int k);
    int ce;
    logic [7:0] cv;
    exp_t e;
    if ($onehot(r) && n >= M) begin
      ce = k + M;
      cv = (M - 1 < chg) ? c0 : c1;
      if (ce - last_cap > TMO) mseen = 0;
      mbuf[idx_of(r)*8 +: 8] = cv;
      mseen[idx_of(r)] = 1'b1;
      last_cap = ce;
      for (int i = M; i < n; i++) if (((i < chg) ? c0 : c1) != cv) exp_tear++;
      if (mseen == 8'hFF) begin
        mcnt++;
        e.f = mbuf;
        e.e = ce + 1;
        e.cnt = mcnt;
        e.pop = pop_of(mbuf);
        q.push_back(e);
        mseen = 0;
      end
    end else if (r != 0 && !$onehot(r)) exp_multi += n;
  endtask

  task automatic seg(input logic [7:0] r, input int n, input logic [7:0] c0 = 0,
                     input int chg = 1000, input logic [7:0] c1 = 0);
    model(r, n, c0, chg, c1, edge_n + 1);
    for (int i = 0; i < n; i++) begin
      row = r;
      col = (i < chg) ? c0 : c1;
      @(negedge clk);
    end
    prev_row = r;
  endtask

  task automatic scan_rows(input int lo, input int hi, input int n);
    for (int r = lo; r <= hi; r++) seg(8'(1) << r, n, (r % 2 == 1) ? 8'h3C : 8'hA5);
  endtask

  task automatic phase_end(input string name);
    seg(0, 4);
    chk({name, " pending frames"}, 64'(q.size()), 0);
    chk({name, " err_multi count"}, 64'(dut_multi), 64'(exp_multi));
    chk({name, " err_tear count"}, 64'(dut_tear), 64'(exp_tear));
  endtask

  task automatic chk_stall();
    chk("stall", 64'(stall), 64'(edge_n - last_cap >= TMO));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " frame"}, frame, 0);
    chk({name, " frame_valid"}, 64'(frame_valid), 0);
    chk({name, " frame_cnt"}, 64'(frame_cnt), 0);
    chk({name, " err_multi"}, 64'(err_multi), 0);
    chk({name, " err_tear"}, 64'(err_tear), 0);
    chk({name, " stall"}, 64'(stall), 0);
    chk({name, " pop"}, 64'(pop), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    if (rst_n) begin
      if (err_multi) dut_multi++;
      if (err_tear) dut_tear++;
      if (frame_valid) begin
        chk("frame_valid expected", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          x = q.pop_front();
          chk("frame", frame, x.f);
          chk("frame_valid edge", 64'(edge_n), 64'(x.e));
          chk("frame_cnt", 64'(frame_cnt), 64'(x.cnt));
          chk("pop", 64'(pop), 64'(x.pop));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int a, b, n, chg;
    logic [7:0] r;
    #2 rst_n = 0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    last_cap = edge_n;

    scan_rows(0, 7, 6);
    phase_end("basic scan");

    scan_rows(0, 2, 6);
    seg(8'h08, 3, 8'h3C);
    scan_rows(4, 7, 6);
    phase_end("short row3");
    seg(8'h08, 6, 8'h3C);
    phase_end("row3 redo");

    scan_rows(0, 3, 6);
    seg(8'h18, 1, 8'h77);
    scan_rows(4, 7, 6);
    phase_end("multi-hot");

    scan_rows(0, 1, 6);
    seg(8'h04, 8, 8'hFF, 6, 8'h00);
    scan_rows(3, 7, 6);
    phase_end("tear");

    scan_rows(0, 3, 6);
    seg(0, 1000);
    chk_stall();
    repeat (40) begin
      seg(0, 1);
      chk_stall();
    end
    seg(0, 60);
    chk_stall();
    scan_rows(0, 7, 6);
    phase_end("timeout rescan");
    chk_stall();

    scan_rows(0, 4, 6);
    seg(0, 2);
    rst_n = 0;
    #1 chk_reset_outputs("mid-frame reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    mbuf = 0;
    mseen = 0;
    mcnt = 0;
    prev_row = 0;
    last_cap = edge_n;
    scan_rows(5, 7, 6);
    phase_end("partial after reset");
    scan_rows(0, 4, 6);
    phase_end("rescan after reset");

    for (int s = 0; s < 400; s++) begin
      a = $urandom_range(0, 19);
      n = $urandom_range(1, 9);
      if (a == 0) r = 0;
      else if (a == 1) begin
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        r = (8'(1) << a) | (8'(1) << b);
      end else begin
        r = 8'(1) << $urandom_range(0, 7);
        if (r == prev_row) r = {r[6:0], r[7]};
      end
      chg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 1000;
      seg(r, n, 8'($urandom), chg, 8'($urandom));
    end
    phase_end("random");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/life_scan_rx.md
# life_scan_rx

Receiver for the multiplexed LED-matrix scan produced by the life display path (`row`/`col`). It samples the scan lines, glitch-filters each row dwell, and reassembles a complete X×Y frame. When every row has been captured it publishes the frame with a one-cycle strobe. It sits beside the display outputs as a self-check/readback port and as the bench-side frame grabber.

## Interface
Parameters:
- X, 8, number of rows (width of `row`)
- Y, 8, number of columns (width of `col`)
- LOG2X, 3, log2(X)
- LOG2Y, 3, log2(Y)
- MIN_DWELL, 4, consecutive identical samples needed before a row is captured (≥2)
- TIMEOUT, 1024, cycles without a capture before `stall` is raised
- CNT_W, 16, width of `frame_cnt`

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- row  in  X  one-hot row select, active-high; all-zero means blanking
- col  in  Y  lit pattern for the selected row, active-high
- frame  out  X*Y  last complete frame; bit r*Y+c is row r, column c
- frame_valid  out  1  one-cycle pulse when `frame` updates
- frame_cnt  out  CNT_W  completed-frame count, wraps modulo 2^CNT_W
- err_multi  out  1  pulse: sampled `row` had more than one bit set
- err_tear  out  1  pulse: `col` changed after capture within the same row dwell
- stall  out  1  level: no capture for TIMEOUT cycles
- pop  out  LOG2X+LOG2Y+1  live-cell count of `frame` (see Configuration)

## Operation
- Input stage: `row`/`col` are registered into s1 every cycle. The previous s1 is held in s2.
- Dwell counter: increments while s1.row == s2.row and s1.row is one-hot. It resets to 0 on any row change, blanking, or multi-hot. It saturates after capture.
- Capture: when s1 has held the same one-hot row for MIN_DWELL consecutive samples:
  - s1.col is written into row buffer[index(row)];
  - the row's bit is set in the `seen` mask;
  - the captured value is kept for the tear check.
  - Exactly one capture occurs per dwell.
- Re-capture of a row already in `seen` overwrites the buffer. This is legal.
- Blanking (row == 0): ignored; resets dwell only.
- Multi-hot row: `err_multi` pulses, dwell resets, no capture.
- Tear: after capture, while the row is unchanged, s1.col ≠ captured value → `err_tear` pulses each such cycle. The buffer is not modified.
- Frame completion: `seen` all ones → next edge: `frame` ← buffer, `frame_valid`=1, `frame_cnt`++, `seen` cleared.
- Timeout counter: cleared on capture, otherwise increments and saturates at TIMEOUT.
  - On reaching TIMEOUT: `stall`=1 and `seen` cleared, discarding the partial frame.
  - `stall` clears on the next capture.
- Simultaneous capture and completion of the previous frame cannot occur; completion always follows capture by one edge.

## Timing
- Reset values: `frame`=0, `frame_valid`=0, `frame_cnt`=0, `err_multi`=0, `err_tear`=0, `stall`=0, `pop`=0. Buffer, `seen` and all counters are 0.
- Let edge k be the first edge sampling a new row into s1. The buffer and `seen` update at edge k+MIN_DWELL.
- If that row completes the frame, `frame`, `frame_valid` and `frame_cnt` update at edge k+MIN_DWELL+1.
- `err_multi` is asserted for the cycle after the edge that sampled the multi-hot row into s1. `err_tear` follows the same rule.
- A row dwell shorter than MIN_DWELL samples is never captured.
- Reset mid-frame discards the buffer and `seen`. `frame` returns to 0.

## Configuration
- LIFE_SCAN_RX_POP_EN defined: `pop` is registered on the same edge as `frame` and equals the popcount of the new frame.
- Not defined: `pop` is tied to 0 and no adder tree is synthesized.

## Structure
- Package life_scan_pkg holds:
  - default MIN_DWELL, TIMEOUT and CNT_W constants;
  - the row one-hot→index function;
  - the one-hot validity check function;
  - the popcount function.
- One sub-module, life_scan_dwell, contains the s1/s2 stage, the dwell counter, the capture strobe and the tear/multi detection. It outputs the capture strobe, the row index and the column data.

## Test plan
- Scan rows 0..7 with X=Y=8, dwell 6 cycles each, col=8'hA5 for even rows and 8'h3C for odd rows:
  - `frame_valid` pulses once, at edge k7+5;
  - `frame` matches the pattern;
  - `frame_cnt`=1;
  - `pop`=32 with POP_EN.
- Same scan but row 3 dwell only 3 cycles → no `frame_valid`. A later valid row-3 dwell completes the frame.
- Apply row=8'h18 for one cycle mid-scan → `err_multi` pulses once. No capture, and the frame still completes afterwards.
- Toggle col from 8'hFF to 8'h00 two cycles after row 2's capture → `err_tear` pulses. Row 2 of `frame` stays 8'hFF.
- Hold row=0 for 1100 cycles after 4 captured rows → `stall`=1 at cycle 1024 and the partial frame is discarded. A full rescan then yields `frame_valid` and `stall`=0.
- Assert reset after 5 rows are captured → all outputs 0. A full rescan is needed for the next `frame_valid`, and `frame_cnt` restarts at 1.
